// File: rtl/filter3x3_pipe_pkg.sv
// Shared constants for the 3x3 neighbourhood filter: mode encoding, tap indices
// and the Gaussian normalisation/rounding constants.
package filter_pkg;

  typedef enum logic [1:0] {
    MODE_GAUSS  = 2'd0,
    MODE_MIN    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_CENTRE = 2'd3
  } mode_e;

  localparam int TAP_CENTRE  = 4;
  localparam int GAUSS_SHIFT = 4;
  localparam int GAUSS_RND   = 8;

endpackage

// File: rtl/filter3x3_row.sv
// Combinational 3-tap reducer: a+2b+c, min, max or middle tap, chosen by mode.
// Used per row in S1 and again across the three row results in S2.
module filter3x3_row
  import filter_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic [IW-1:0] i_a,
  input  logic [IW-1:0] i_b,
  input  logic [IW-1:0] i_c,
  input  mode_e         i_mode,
  output logic [IW+1:0] o_res
);

  logic [IW+1:0] w_a;
  logic [IW+1:0] w_b;
  logic [IW+1:0] w_c;
  logic [IW+1:0] w_min;
  logic [IW+1:0] w_max;

  assign w_a = {2'b00, i_a};
  assign w_b = {2'b00, i_b};
  assign w_c = {2'b00, i_c};

  always_comb begin
    w_min = w_a;
    if (w_b < w_min) w_min = w_b;
    if (w_c < w_min) w_min = w_c;
    w_max = w_a;
    if (w_b > w_max) w_max = w_b;
    if (w_c > w_max) w_max = w_c;
  end

  // The middle tap is the centre of the row; for the centre row that is tap 4.
  always_comb begin
    o_res = '0;
    case (i_mode)
      MODE_GAUSS:  o_res = w_a + (w_b << 1) + w_c;
      MODE_MIN:    o_res = w_min;
      MODE_MAX:    o_res = w_max;
      MODE_CENTRE: o_res = w_b;
    endcase
  end

endmodule

// File: rtl/filter3x3_pipe.sv
// Three-stage pipelined 3x3 filter (Gaussian / min / max / centre) with
// valid/ready backpressure. Define FILTER3X3_ROUND_EN for round-half-up Gaussian.
module filter3x3_pipe
  import filter_pkg::*;
#(
  parameter int DW     = 8,
  parameter int NUM_CH = 3,
  parameter int TAG_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*9*DW-1:0] in_win,
  input  logic [1:0]             in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH*DW-1:0]   out_pix,
  output logic [TAG_W-1:0]       out_tag
);

  logic                            w_adv;
  mode_e                           w_in_mode;
  logic [NUM_CH-1:0][2:0][DW+1:0]  w_s1_row;
  logic [NUM_CH-1:0][DW+3:0]       w_s2_sum;
  logic [NUM_CH-1:0][DW-1:0]       w_s3_pix;

  logic                            r_s1_vld;
  mode_e                           r_s1_mode;
  logic [TAG_W-1:0]                r_s1_tag;
  logic [NUM_CH-1:0][2:0][DW+1:0]  r_s1_row;

  logic                            r_s2_vld;
  mode_e                           r_s2_mode;
  logic [TAG_W-1:0]                r_s2_tag;
  logic [NUM_CH-1:0][DW+3:0]       r_s2_sum;

  logic                            r_out_valid;
  logic [TAG_W-1:0]                r_out_tag;
  logic [NUM_CH-1:0][DW-1:0]       r_out_pix;

  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign w_in_mode = mode_e'(in_mode);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    for (genvar row = 0; row < 3; row++) begin : g_row
      filter3x3_row #(.IW(DW)) u_row (
        .i_a    (in_win[(ch*9 + row*3 + 0)*DW +: DW]),
        .i_b    (in_win[(ch*9 + row*3 + 1)*DW +: DW]),
        .i_c    (in_win[(ch*9 + row*3 + 2)*DW +: DW]),
        .i_mode (w_in_mode),
        .o_res  (w_s1_row[ch][row])
      );
    end

    // Row results reused as taps: R0 + 2*R1 + R2, or min/max/centre of rows.
    filter3x3_row #(.IW(DW + 2)) u_comb (
      .i_a    (r_s1_row[ch][0]),
      .i_b    (r_s1_row[ch][1]),
      .i_c    (r_s1_row[ch][2]),
      .i_mode (r_s1_mode),
      .o_res  (w_s2_sum[ch])
    );

    logic [DW+3:0] w_biased;

    always_comb begin
`ifdef FILTER3X3_ROUND_EN
      w_biased = r_s2_sum[ch] + (DW+4)'(GAUSS_RND);
`else
      w_biased = r_s2_sum[ch];
`endif
      if (r_s2_mode == MODE_GAUSS) begin
        w_s3_pix[ch] = DW'(w_biased >> GAUSS_SHIFT);
      end else begin
        w_s3_pix[ch] = r_s2_sum[ch][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_mode   <= MODE_GAUSS;
      r_s1_tag    <= '0;
      r_s1_row    <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_mode   <= MODE_GAUSS;
      r_s2_tag    <= '0;
      r_s2_sum    <= '0;
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_pix   <= '0;
    end else if (w_adv) begin
      r_s1_vld    <= in_valid;
      r_s1_mode   <= w_in_mode;
      r_s1_tag    <= in_tag;
      r_s1_row    <= w_s1_row;
      r_s2_vld    <= r_s1_vld;
      r_s2_mode   <= r_s1_mode;
      r_s2_tag    <= r_s1_tag;
      r_s2_sum    <= w_s2_sum;
      r_out_valid <= r_s2_vld;
      r_out_tag   <= r_s2_tag;
      r_out_pix   <= w_s3_pix;
    end
  end

  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign out_pix   = r_out_pix;

endmodule

// File: tb/tb_filter3x3_pipe.sv
// Self-checking bench for filter3x3_pipe: directed cases plus randomized
// backpressure against a scoreboard of windows filtered by plain arithmetic.
module tb_filter3x3_pipe;
  import filter_pkg::*;

  localparam int DW     = 8;
  localparam int NUM_CH = 3;
  localparam int TAG_W  = 2;
  localparam int MAXV   = (1 << DW) - 1;
  localparam int GW [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  typedef struct {
    logic [NUM_CH*DW-1:0] pix;
    logic [TAG_W-1:0]     tag;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_CH*9*DW-1:0] in_win;
  logic [1:0]             in_mode;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CH*DW-1:0]   out_pix;
  logic [TAG_W-1:0]       out_tag;

  filter3x3_pipe #(.DW(DW), .NUM_CH(NUM_CH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_win    (in_win),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int                   win [NUM_CH][9];
  int                   cur_mode;
  int                   cur_tag;
  int                   n_tests = 0;
  int                   n_fail  = 0;
  int                   n_in    = 0;
  int                   n_out   = 0;
  exp_t                 sb [$];
  logic                 prev_stall = 1'b0;
  logic [NUM_CH*DW-1:0] prev_pix;
  logic [TAG_W-1:0]     prev_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_ch(input int c, input int mode);
    int s;
    int m;
    s = 0;
    if (mode == MODE_GAUSS) begin
      for (int k = 0; k < 9; k++) s += GW[k] * win[c][k];
`ifdef FILTER3X3_ROUND_EN
      return (s + 8) / 16;
`else
      return s / 16;
`endif
    end else if (mode == MODE_MIN) begin
      m = win[c][0];
      for (int k = 1; k < 9; k++) if (win[c][k] < m) m = win[c][k];
      return m;
    end else if (mode == MODE_MAX) begin
      m = win[c][0];
      for (int k = 1; k < 9; k++) if (win[c][k] > m) m = win[c][k];
      return m;
    end
    return win[c][TAP_CENTRE];
  endfunction

  function automatic exp_t model_beat();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) e.pix[c*DW +: DW] = DW'(ref_ch(c, cur_mode));
    e.tag = TAG_W'(cur_tag);
    return e;
  endfunction

  task automatic apply(input int mode, input int tag);
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 9; k++) in_win[(c*9 + k)*DW +: DW] = DW'(win[c][k]);
    in_mode  = 2'(mode);
    in_tag   = TAG_W'(tag);
    cur_mode = mode;
    cur_tag  = tag;
    in_valid = 1'b1;
  endtask

  task automatic set_win(input int t [9]);
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 9; k++) win[c][k] = t[k];
  endtask

  task automatic rand_win();
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 9; k++) win[c][k] = int'($urandom_range(0, MAXV));
  endtask

  // Sample point is 2 ns after the falling edge; returns at the next falling edge.
  task automatic tick();
    exp_t e;
    #2;
    if (rst_n) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_pix", out_pix, prev_pix);
        check("stall_tag", out_tag, prev_tag);
      end
      if (in_valid && in_ready) begin
        sb.push_back(model_beat());
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("pix", out_pix, e.pix);
          check("tag", out_tag, e.tag);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pix;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run_one(input int mode, input int tag, input int exp0, input string nm);
    int lat;
    out_ready = 1'b1;
    apply(mode, tag);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
    check(nm, out_pix[DW-1:0], exp0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t [9];
    int start_in;
    int start_out;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_win    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    t = '{MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV};
    set_win(t);
    run_one(MODE_GAUSS, 1, 255, "gauss_max");

    t = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    set_win(t);
    run_one(MODE_GAUSS, 2, 5, "gauss_ramp");

    t = '{0, 0, 0, 0, 2, 0, 0, 0, 1};
    set_win(t);
`ifdef FILTER3X3_ROUND_EN
    run_one(MODE_GAUSS, 3, 1, "gauss_round");
`else
    run_one(MODE_GAUSS, 3, 0, "gauss_trunc");
`endif

    // Back-to-back min, max, centre beats.
    t = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    set_win(t);
    out_ready = 1'b1;
    apply(MODE_MIN, 0);
    tick();
    apply(MODE_MAX, 1);
    tick();
    apply(MODE_CENTRE, 2);
    tick();
    in_valid = 1'b0;
    check("seq_min_valid", out_valid, 1'b1);
    check("seq_min", out_pix[DW-1:0], 1);
    check("seq_min_tag", out_tag, 0);
    tick();
    check("seq_max", out_pix[DW-1:0], 9);
    check("seq_max_tag", out_tag, 1);
    tick();
    check("seq_centre", out_pix[DW-1:0], 5);
    check("seq_centre_tag", out_tag, 2);
    drain();

    // Output blocked with input pushing: the pipe fills to exactly three beats.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_win();
      apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      tick();
    end
    check("fill_depth", sb.size(), 3);
    check("fill_ready", in_ready, 1'b0);
    drain();

    // Ten beats under random backpressure.
    start_in  = n_in;
    start_out = n_out;
    for (int cyc = 0; cyc < 300 && (n_in - start_in) < 10; cyc++) begin
      rand_win();
      apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("bp_accepted", n_in - start_in, 10);
    drain();
    check("bp_delivered", n_out - start_out, 10);

    // Longer random traffic with bubbles on both sides.
    for (int cyc = 0; cyc < 300; cyc++) begin
      rand_win();
      apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_win();
      apply(MODE_MAX, i);
      tick();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_pix", out_pix, 0);
    check("midrst_tag", out_tag, 0);
    sb.delete();
    prev_stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_idle", out_valid, 1'b0);
    end
    t = '{MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV, MAXV};
    set_win(t);
    run_one(MODE_GAUSS, 3, 255, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
